// File: rtl/position_stream_out.sv
// position_stream_out
// Captures the positions list from find_all_ones_iterative on done_i and
// serialises it as a valid/ready stream of {word, position} indices. Each
// word ends with a word_done_o pulse. The last word of a frame also raises
// frame_done_o.
module position_stream_out #(
    parameter  int N         = 16,
    parameter  int NUM_WORDS = 4,
    localparam int LOGN      = $clog2(N),
    localparam int LOGW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       done_i,
    input  logic [N-1:0][LOGN-1:0]     positions_i,
    input  logic [LOGN:0]              count_i,
    input  logic                       empty_i,
    input  logic                       word_clear_i,
    output logic                       ready_o,
    output logic [LOGW+LOGN-1:0]       idx_o,
    output logic                       idx_valid_o,
    input  logic                       idx_ready_i,
    output logic                       idx_last_o,
    output logic                       word_done_o,
    output logic                       frame_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WORD_END
    } state_t;

    state_t                  state_q, state_d;
    logic [N-1:0][LOGN-1:0]  pos_q;
    logic [LOGN:0]           cnt_q;
    logic [LOGN:0]           cnt_clamped;
    logic [LOGN-1:0]         ptr_q;
    logic [LOGW-1:0]         word_q;
    logic                    capture;
    logic                    advance;
    logic                    last;
    logic                    word_wrap;

    // count_i can encode up to 2N-1; anything beyond N is clamped to N
    assign cnt_clamped = (count_i > (LOGN+1)'(N)) ? (LOGN+1)'(N) : count_i;
    assign last        = ({1'b0, ptr_q} == (cnt_q - (LOGN+1)'(1)));
    assign word_wrap   = (word_q == LOGW'(NUM_WORDS - 1));

    // Next-state and Moore outputs, all decoded from the current state
    always_comb begin
        state_d      = state_q;
        ready_o      = 1'b0;
        idx_valid_o  = 1'b0;
        idx_o        = '0;
        idx_last_o   = 1'b0;
        word_done_o  = 1'b0;
        frame_done_o = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (done_i) begin
                    capture = 1'b1;
                    state_d = (empty_i || (count_i == '0)) ? WORD_END : STREAM;
                end
            end
            STREAM: begin
                idx_valid_o = 1'b1;
                idx_o       = {word_q, pos_q[ptr_q]};
                idx_last_o  = last;
                if (idx_ready_i) begin
                    if (last) state_d = WORD_END;
                    else      advance = 1'b1;
                end
            end
            WORD_END: begin
                word_done_o  = 1'b1;
                frame_done_o = word_wrap;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Capture registers, read pointer and word counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
            word_q <= '0;
        end else begin
            if (capture) begin
                pos_q <= positions_i;
                cnt_q <= cnt_clamped;
                ptr_q <= '0;
            end else if (advance) begin
                ptr_q <= ptr_q + 1'b1;
            end
            // A clear coinciding with done_i tags the captured word as 0
            if (state_q == IDLE && word_clear_i) begin
                word_q <= '0;
            end else if (state_q == WORD_END) begin
                word_q <= word_wrap ? '0 : word_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_position_stream_out.sv
// Testbench for position_stream_out: a reference model pushes expected
// indices and word-end flags into queues as each word is offered, and a
// monitor pops and compares them as the DUT emits.
module tb_position_stream_out;

    localparam int N  = 16;
    localparam int NW = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  done_i;
    logic [N-1:0][3:0]     positions_i;
    logic [4:0]            count_i;
    logic                  empty_i;
    logic                  word_clear_i;
    logic                  ready_o;
    logic [5:0]            idx_o;
    logic                  idx_valid_o;
    logic                  idx_ready_i;
    logic                  idx_last_o;
    logic                  word_done_o;
    logic                  frame_done_o;

    typedef struct {
        logic [5:0] idx;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    bit         wd_q[$];
    exp_t       e;
    bit         wf;
    int         asserts = 0;
    int         fails   = 0;
    int         hs_count = 0;
    int         tb_word = 0;
    bit         prev_stall = 0;
    logic [5:0] prev_idx;
    logic       prev_last;

    position_stream_out #(.N(N), .NUM_WORDS(NW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .done_i       (done_i),
        .positions_i  (positions_i),
        .count_i      (count_i),
        .empty_i      (empty_i),
        .word_clear_i (word_clear_i),
        .ready_o      (ready_o),
        .idx_o        (idx_o),
        .idx_valid_o  (idx_valid_o),
        .idx_ready_i  (idx_ready_i),
        .idx_last_o   (idx_last_o),
        .word_done_o  (word_done_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: stall stability, index order and word-end flags
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (prev_stall) begin
                asserts++;
                if (idx_valid_o !== 1'b1 || idx_o !== prev_idx || idx_last_o !== prev_last) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%0b idx=%h last=%0b, required valid=1 idx=%h last=%0b",
                             idx_valid_o, idx_o, idx_last_o, prev_idx, prev_last);
                end
            end
            if (idx_valid_o && idx_ready_i) begin
                hs_count++;
                asserts++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL idx_unexpected: idx=%h last=%0b, required no index", idx_o, idx_last_o);
                end else begin
                    e = exp_q.pop_front();
                    if (idx_o !== e.idx || idx_last_o !== e.last) begin
                        fails++;
                        $display("FAIL idx_value: idx=%h last=%0b, required idx=%h last=%0b",
                                 idx_o, idx_last_o, e.idx, e.last);
                    end
                end
            end
            if (word_done_o) begin
                asserts++;
                if (wd_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_done_unexpected: word_done=1, required 0");
                end else begin
                    wf = wd_q.pop_front();
                    if (frame_done_o !== wf) begin
                        fails++;
                        $display("FAIL frame_done: got %0b, required %0b", frame_done_o, wf);
                    end
                end
            end else if (frame_done_o) begin
                asserts++;
                fails++;
                $display("FAIL frame_done_alone: frame_done=1 without word_done");
            end
            prev_stall = idx_valid_o && !idx_ready_i;
            prev_idx   = idx_o;
            prev_last  = idx_last_o;
        end else begin
            prev_stall = 0;
        end
    end

    // Offer one word; when model=1 the expected stream is pushed too
    task automatic pulse_done(input logic [N-1:0][3:0] pos, input int cnt,
                              input bit empty, input bit clear, input bit model);
        int n;
        int tag;
        exp_t x;
        @(posedge clk_i); #1;
        positions_i  = pos;
        count_i      = 5'(cnt);
        empty_i      = empty;
        word_clear_i = clear;
        done_i       = 1'b1;
        if (model) begin
            n   = (empty || cnt == 0) ? 0 : ((cnt > N) ? N : cnt);
            tag = clear ? 0 : tb_word;
            for (int i = 0; i < n; i++) begin
                x.idx  = {2'(tag), pos[i]};
                x.last = (i == n - 1);
                exp_q.push_back(x);
            end
            wd_q.push_back(tag == NW - 1);
            tb_word = (tag + 1) % NW;
        end
        @(posedge clk_i); #1;
        done_i       = 1'b0;
        word_clear_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && wd_q.size() == 0 && ready_o === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; done_i = 0; positions_i = '0; count_i = '0;
        empty_i = 0; word_clear_i = 0; idx_ready_i = 1;
        #12;
        asserts++;
        if ({ready_o, idx_valid_o, idx_o, idx_last_o, word_done_o, frame_done_o} !== 11'b1_0_000000_0_0_0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%0b v=%0b idx=%h last=%0b wd=%0b fd=%0b, required rdy=1 rest 0",
                     ready_o, idx_valid_o, idx_o, idx_last_o, word_done_o, frame_done_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_empty;
        logic [N-1:0][3:0] p;
        bit ok;
        p = '0;
        pulse_done(p, 0, 1, 0, 1);
        @(negedge clk_i);
        asserts++;
        if (idx_valid_o !== 1'b0 || word_done_o !== 1'b1 || frame_done_o !== 1'b0) begin
            fails++;
            $display("FAIL empty_T1: v=%0b wd=%0b fd=%0b, required v=0 wd=1 fd=0", idx_valid_o, word_done_o, frame_done_o);
        end
        @(negedge clk_i);
        asserts++;
        if (ready_o !== 1'b1 || idx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL empty_T2: rdy=%0b v=%0b, required rdy=1 v=0", ready_o, idx_valid_o);
        end
        // single-entry word shows the counter advanced to 1 (expect 0x15)
        p[0] = 4'd5;
        pulse_done(p, 1, 0, 0, 1);
        wait_drain(50, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL empty_drain: exp=%0d wd=%0d, required 0 0", exp_q.size(), wd_q.size()); end
    endtask

    task automatic test_word0;
        logic [N-1:0][3:0] p;
        bit ok;
        p = '0;
        for (int i = 0; i < 4; i++) p[i] = 4'(i * 4);
        pulse_done(p, 4, 0, 1, 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            asserts++;
            if (idx_valid_o !== (c <= 4) || word_done_o !== (c == 5) || ready_o !== (c == 6)) begin
                fails++;
                $display("FAIL word0_timing c=%0d: v=%0b wd=%0b rdy=%0b, required v=%0b wd=%0b rdy=%0b",
                         c, idx_valid_o, word_done_o, ready_o, c <= 4, c == 5, c == 6);
            end
        end
        wait_drain(20, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL word0_drain: exp=%0d wd=%0d, required 0 0", exp_q.size(), wd_q.size()); end
    endtask

    task automatic test_backpressure;
        logic [N-1:0][3:0] p;
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int hs0;
        bit ok;
        p = '0;
        for (int i = 0; i < 4; i++) p[i] = 4'(i * 4);
        hs0 = hs_count;
        pulse_done(p, 4, 0, 0, 1);
        for (int j = 0; j < 7; j++) begin
            idx_ready_i = pat[j];
            @(posedge clk_i); #1;
        end
        idx_ready_i = 1'b1;
        wait_drain(50, ok);
        asserts++;
        if (!ok || hs_count - hs0 != 4) begin
            fails++;
            $display("FAIL backpressure_handshakes: got %0d drained=%0b, required 4 drained=1", hs_count - hs0, ok);
        end
    endtask

    task automatic test_frame;
        logic [N-1:0][3:0] p;
        bit ok;
        for (int w = 0; w < 4; w++) begin
            p = '0;
            case (w)
                0: for (int i = 0; i < N; i++) p[i] = 4'(i);
                1: p[0] = 4'd15;
                2: ;
                default: begin p[0] = 4'd3; p[1] = 4'd7; end
            endcase
            pulse_done(p, (w == 0) ? 16 : (w == 1) ? 1 : (w == 2) ? 0 : 2, 0, w == 0, 1);
            wait_drain(60, ok);
            asserts++;
            if (!ok) begin fails++; $display("FAIL frame_word%0d_drain: exp=%0d wd=%0d, required 0 0", w, exp_q.size(), wd_q.size()); end
        end
    endtask

    task automatic test_ignore_and_clear;
        logic [N-1:0][3:0] p, junk;
        bit ok;
        p = '0;
        for (int i = 0; i < 4; i++) p[i] = 4'(i + 1);
        for (int i = 0; i < N; i++) junk[i] = 4'd9;
        pulse_done(p, 4, 0, 0, 1);
        asserts++;
        if (ready_o !== 1'b0) begin fails++; $display("FAIL busy_ready: got %0b, required 0", ready_o); end
        pulse_done(junk, 3, 0, 1, 0);
        wait_drain(40, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL ignore_drain: exp=%0d wd=%0d, required 0 0", exp_q.size(), wd_q.size()); end
        // bring the counter to 2, then clear together with done
        pulse_done(junk, 0, 0, 0, 1);
        wait_drain(20, ok);
        p = '0; p[0] = 4'd6; p[1] = 4'd9;
        pulse_done(p, 2, 0, 1, 1);
        wait_drain(40, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL clear_drain: exp=%0d wd=%0d, required 0 0", exp_q.size(), wd_q.size()); end
    endtask

    task automatic test_clamp;
        logic [N-1:0][3:0] p;
        bit ok;
        for (int i = 0; i < N; i++) p[i] = 4'(i);
        pulse_done(p, 31, 0, 0, 1);
        wait_drain(60, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL clamp_drain: exp=%0d wd=%0d, required 0 0", exp_q.size(), wd_q.size()); end
    endtask

    task automatic test_reset_midstream;
        logic [N-1:0][3:0] p;
        bit ok;
        for (int i = 0; i < N; i++) p[i] = 4'(i);
        pulse_done(p, 8, 0, 0, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        asserts++;
        if ({ready_o, idx_valid_o, idx_o, idx_last_o, word_done_o, frame_done_o} !== 11'b1_0_000000_0_0_0) begin
            fails++;
            $display("FAIL async_reset: rdy=%0b v=%0b idx=%h last=%0b wd=%0b fd=%0b, required rdy=1 rest 0",
                     ready_o, idx_valid_o, idx_o, idx_last_o, word_done_o, frame_done_o);
        end
        exp_q.delete();
        wd_q.delete();
        tb_word = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            asserts++;
            if (word_done_o !== 1'b0 || idx_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold c=%0d: wd=%0b v=%0b, required 0 0", c, word_done_o, idx_valid_o);
            end
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        p = '0; p[0] = 4'd5; p[1] = 4'd10;
        pulse_done(p, 2, 0, 0, 1);
        wait_drain(40, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL post_reset_drain: exp=%0d wd=%0d, required 0 0", exp_q.size(), wd_q.size()); end
    endtask

    initial begin
        test_reset;
        test_empty;
        test_word0;
        test_backpressure;
        test_frame;
        test_ignore_and_clear;
        test_clamp;
        test_reset_midstream;
        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
